// File: rtl/seven_seg_scan_ctrl.sv
// seven_seg_scan_ctrl
// Time-multiplexing scheduler that drives one shared 7-segment bus across
// NDIG digits. Digits are scanned round-robin. Each slot is one SHOW tick
// followed by one dark GAP tick. Brightness is a PWM of the digit enable
// within SHOW. New frames are applied only at frame boundaries, so a scan
// never mixes old and new digits.
//
// Optional build macro:
//   SEVEN_SEG_ACTIVE_LOW_EN - when defined, segment and digit_en are driven
//   inverted for common-anode hardware (reset/dark value is all ones).
//
// Ports:
//   clk, rst      clock; synchronous active-high reset
//   wr_valid      new frame offered
//   wr_ready      controller can accept a frame (no frame pending)
//   wr_data       7*NDIG segment patterns, digit i = wr_data[7*i+6:7*i]
//   wr_blank      per-digit blank mask, 1 = dark
//   brightness    PWM level 0..7, sampled every cycle
//   segment       shared segment bus (registered)
//   digit_en      one-hot digit enable (registered)
//   frame_done    one-cycle pulse marking each frame boundary (registered)
//
// Handshake: a frame transfers on every clk edge where wr_valid && wr_ready
// are both high. wr_ready depends only on internal state, never on wr_valid.
// A source seeing wr_ready low must hold wr_valid and its data until the
// transfer happens.

module seven_seg_scan_ctrl #(
  parameter int NDIG     = 4,
  parameter int TICK_DIV = 5000,
  parameter int CBITS    = 13
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [7*NDIG-1:0]   wr_data,
  input  logic [NDIG-1:0]     wr_blank,
  input  logic [2:0]          brightness,
  output logic [6:0]          segment,
  output logic [NDIG-1:0]     digit_en,
  output logic                frame_done
);

  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CBITS-1:0] CNT_MAX  = CBITS'(TICK_DIV - 1);
  localparam logic [IW-1:0]    IDX_LAST = IW'(NDIG - 1);
  localparam logic [CBITS+2:0] DIV_W    = (CBITS+3)'(TICK_DIV);

`ifdef SEVEN_SEG_ACTIVE_LOW_EN
  localparam logic OUT_INV = 1'b1;
`else
  localparam logic OUT_INV = 1'b0;
`endif

  typedef enum logic {
    ST_GAP  = 1'b0,
    ST_SHOW = 1'b1
  } state_t;

  state_t            state, state_next;
  logic [IW-1:0]     idx, idx_next;
  logic [CBITS-1:0]  cnt;
  logic              tick;
  logic              boundary;

  logic              pending;
  logic [7*NDIG-1:0] pend_data, act_data;
  logic [NDIG-1:0]   pend_blank, act_blank;

  logic [CBITS+2:0]  bright_p1;
  logic [CBITS+2:0]  thresh;
  logic [6:0]        seg_next;
  logic [NDIG-1:0]   en_next;

  // Prescaler: one tick every TICK_DIV clocks
  always_ff @(posedge clk) begin
    if (rst)       cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + CBITS'(1);
  end

  assign tick = (cnt == CNT_MAX);

  // The GAP->SHOW step out of the last digit is the frame boundary
  assign boundary = tick && (state == ST_GAP) && (idx == IDX_LAST);

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_GAP;
      idx   <= IDX_LAST;
    end else begin
      state <= state_next;
      idx   <= idx_next;
    end
  end

  // FSM: next state, advances only on tick
  always_comb begin
    state_next = state;
    idx_next   = idx;
    if (tick) begin
      case (state)
        ST_GAP: begin
          state_next = ST_SHOW;
          idx_next   = (idx == IDX_LAST) ? '0 : idx + IW'(1);
        end
        ST_SHOW: state_next = ST_GAP;
        default: state_next = ST_GAP;
      endcase
    end
  end

  // Full-width product before the shift so low brightness levels keep
  // their fraction of TICK_DIV; level 7 yields exactly TICK_DIV.
  assign bright_p1 = (CBITS+3)'(brightness) + (CBITS+3)'(1);
  assign thresh    = (bright_p1 * DIV_W) >> 3;

  // FSM: output decode (registered below)
  always_comb begin
    seg_next = '0;
    en_next  = '0;
    if (state == ST_SHOW) begin
      seg_next = act_data[int'(idx)*7 +: 7];
      if (({3'b000, cnt} < thresh) && !act_blank[idx])
        en_next = NDIG'(1) << idx;
    end
  end

  // Write port and frame double-buffer. Acceptance and a pending load can
  // never coincide because wr_ready is low whenever a load is due.
  assign wr_ready = !pending;

  always_ff @(posedge clk) begin
    if (rst) begin
      pending    <= 1'b0;
      pend_data  <= '0;
      pend_blank <= '0;
      act_data   <= '0;
      act_blank  <= '1;
    end else begin
      if (boundary && pending) begin
        act_data  <= pend_data;
        act_blank <= pend_blank;
      end
      if (wr_valid && wr_ready) begin
        pend_data  <= wr_data;
        pend_blank <= wr_blank;
        pending    <= 1'b1;
      end else if (boundary && pending) begin
        pending <= 1'b0;
      end
    end
  end

  // Output registers: pins follow state/cnt by one clock. Polarity is
  // folded in here so the pins come straight from flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      segment    <= {7{OUT_INV}};
      digit_en   <= {NDIG{OUT_INV}};
      frame_done <= 1'b0;
    end else begin
      segment    <= seg_next ^ {7{OUT_INV}};
      digit_en   <= en_next ^ {NDIG{OUT_INV}};
      frame_done <= boundary;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Bench for seven_seg_scan_ctrl (default active-high build), NDIG=4,
// TICK_DIV=8. Expected lit cycles {digit_en, segment} are queued by the
// driver at each frame boundary; a monitor pops one entry per lit cycle.

module tb_seven_seg_scan_ctrl;

  localparam int NDIG     = 4;
  localparam int TICK_DIV = 8;
  localparam int CBITS    = 4;
  localparam int W        = NDIG + 7;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              wr_valid = 1'b0;
  logic              wr_ready;
  logic [7*NDIG-1:0] wr_data = '0;
  logic [NDIG-1:0]   wr_blank = '0;
  logic [2:0]        brightness = 3'd7;
  logic [6:0]        segment;
  logic [NDIG-1:0]   digit_en;
  logic              frame_done;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  bit first_lit_seen = 1'b0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_e;

  // Frames: digit0 in the low slice
  logic [27:0] fr_a = {7'h7F, 7'h5B, 7'h3F, 7'h06};
  logic [27:0] fr_b = {7'h7D, 7'h6D, 7'h66, 7'h4F};
  logic [27:0] fr_c = {7'h77, 7'h6F, 7'h7F, 7'h07};
  logic [27:0] fr_d = {7'h71, 7'h79, 7'h5E, 7'h39};
  logic [27:0] fr_e = {7'h08, 7'h04, 7'h02, 7'h01};

  // Clock / reset-relative cycle counter
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  seven_seg_scan_ctrl #(
    .NDIG(NDIG), .TICK_DIV(TICK_DIV), .CBITS(CBITS)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_data(wr_data), .wr_blank(wr_blank),
    .brightness(brightness),
    .segment(segment), .digit_en(digit_en), .frame_done(frame_done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Driver tasks
  task automatic push_digit(input int i, input logic [6:0] seg, input int n);
    logic [NDIG-1:0] oh;
    oh = NDIG'(1) << i;
    repeat (n) exp_q.push_back({oh, seg});
  endtask

  task automatic push_frame(input logic [27:0] d, input logic [3:0] b, input int lit);
    for (int i = 0; i < NDIG; i++)
      if (!b[i]) push_digit(i, d[7*i +: 7], lit);
  endtask

  task automatic wait_fd();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_done !== 1'b1 && n < 200);
    if (frame_done !== 1'b1) begin
      vectors++;
      miscompares++;
      $display("FAIL frame_done_timeout: no pulse within %0d cycles", n);
    end
  endtask

  task automatic send(input logic [27:0] d, input logic [3:0] b);
    int n;
    n = 0;
    wr_valid = 1'b1;
    wr_data  = d;
    wr_blank = b;
    while (wr_ready !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (wr_ready !== 1'b1) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: wr_ready stuck at %b", wr_ready);
    end
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (digit_en !== '0) begin
      if (!first_lit_seen) begin
        first_lit_seen = 1'b1;
        check("first_lit_cycle", cyc, TICK_DIV + 1);
      end
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_lit: got en=%b seg=%h expected dark (cycle %0d)",
                 digit_en, segment, cyc);
      end else begin
        exp_e = exp_q.pop_front();
        check("scan", {digit_en, segment}, exp_e);
      end
    end
    if (frame_done === 1'b1 || (cyc >= 8 && cyc % 64 == 8))
      check("frame_done_timing", frame_done, (cyc >= 8 && cyc % 64 == 8));
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_segment", segment, 0);
    check("rst_digit_en", digit_en, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_wr_ready", wr_ready, 1);
    rst = 1'b0;

    // Frame A written right after reset, full brightness
    send(fr_a, 4'b0000);
    check("ready_after_accept", wr_ready, 0);
    wait_fd();
    check("ready_after_load", wr_ready, 1);
    push_frame(fr_a, 4'b0000, 8);
    repeat (9) @(negedge clk);
    check("gap_dark", {digit_en, segment}, 0);

    // Dimmed frame: 4 of 8 SHOW cycles lit, segment held all slot
    wait_fd();
    brightness = 3'd3;
    push_frame(fr_a, 4'b0000, 4);
    repeat (7) @(negedge clk);
    check("dim_seg_hold", segment, 7'h06);
    check("dim_en_off", digit_en, 0);

    // B written mid-frame, C offered while B is pending
    repeat (13) @(negedge clk);
    send(fr_b, 4'b0000);
    wr_valid = 1'b1;
    wr_data  = fr_c;
    wr_blank = 4'b0100;
    check("ready_low_while_pending", wr_ready, 0);
    wait_fd();
    check("ready_at_boundary", wr_ready, 1);
    brightness = 3'd7;
    push_frame(fr_b, 4'b0000, 8);
    @(negedge clk);
    wr_valid = 1'b0;
    check("c_accepted_on_fd", wr_ready, 0);

    // C (digit 2 blanked); D offered for exactly the frame_done cycle
    wait_fd();
    push_frame(fr_c, 4'b0100, 8);
    check("ready_on_fd", wr_ready, 1);
    wr_valid = 1'b1;
    wr_data  = fr_d;
    wr_blank = 4'b0000;
    @(negedge clk);
    wr_valid = 1'b0;
    check("d_accepted_on_fd", wr_ready, 0);

    // D at level 5 (6 lit cycles); reset during digit 2 after 2 lit cycles
    wait_fd();
    brightness = 3'd5;
    check("ready_d_loaded", wr_ready, 1);
    push_digit(0, fr_d[6:0], 6);
    push_digit(1, fr_d[13:7], 6);
    push_digit(2, fr_d[20:14], 2);
    repeat (34) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_segment", segment, 0);
    check("mid_rst_digit_en", digit_en, 0);
    check("mid_rst_wr_ready", wr_ready, 1);
    check("mid_rst_frame_done", frame_done, 0);
    check("q_drained_before_rst", exp_q.size(), 0);
    rst = 1'b0;
    brightness = 3'd7;

    // Dark until a new write plus one boundary
    wait_fd();
    check("ready_idle", wr_ready, 1);
    send(fr_e, 4'b0000);
    wait_fd();
    push_frame(fr_e, 4'b0000, 8);
    wait_fd();
    check("queue_empty_end", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
